// File: rtl/multi_way_traffic_ctrl.sv
// N-way intersection controller: round-robin green among requesting ways with min/max green,
// fixed yellow and all-red phases, plus a parade mode that holds one designated way green.
module multi_way_traffic_ctrl #(
  parameter int unsigned N_WAYS        = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned MIN_GREEN     = 4,
  parameter int unsigned MAX_GREEN     = 10,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 1,
  parameter int unsigned PARADE_WAY    = 1,
  localparam int unsigned WAY_W        = $clog2(N_WAYS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_WAYS-1:0]     i_sensor,
  input  logic                  i_parade_set,
  input  logic                  i_parade_clr,
  output logic [2*N_WAYS-1:0]   o_lights,
  output logic [WAY_W-1:0]      o_active_way,
  output logic                  o_parade
);

  localparam logic [CNT_W-1:0] MinGreenM1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxGreenM1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowM1   = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AllredM1   = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [WAY_W-1:0] ParadeWay  = WAY_W'(PARADE_WAY);
  localparam logic [WAY_W-1:0] LastWay    = WAY_W'(N_WAYS - 1);

  typedef enum logic [1:0] {StGreen, StYellow, StAllred} state_e;

  state_e             state_q, state_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [WAY_W-1:0]   next_way_q, next_way_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               parade_q, parade_d;

  logic [N_WAYS-1:0]  own_mask;
  logic               other_req;
  logic               leave;
  logic               found;
  logic [WAY_W-1:0]   cand;
  logic [WAY_W-1:0]   rr_way;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StGreen;
      way_q      <= '0;
      next_way_q <= '0;
      cnt_q      <= '0;
      parade_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      next_way_q <= next_way_d;
      cnt_q      <= cnt_d;
      parade_q   <= parade_d;
    end
  end

  always_comb begin
    own_mask          = '0;
    own_mask[way_q]   = 1'b1;
    other_req         = |(i_sensor & ~own_mask);

    if (parade_q) begin
      leave = (way_q != ParadeWay) && (cnt_q >= MinGreenM1);
    end else begin
      leave = other_req && (cnt_q >= MinGreenM1) && (!i_sensor[way_q] || (cnt_q >= MaxGreenM1));
    end

    // Round-robin search starting just after the current way, wrapping.
    rr_way = way_q;
    found  = 1'b0;
    cand   = way_q;
    for (int unsigned i = 1; i < N_WAYS; i++) begin
      cand = (cand == LastWay) ? '0 : cand + 1'b1;
      if (!found && i_sensor[cand]) begin
        rr_way = cand;
        found  = 1'b1;
      end
    end

    state_d    = state_q;
    way_d      = way_q;
    next_way_d = next_way_q;
    cnt_d      = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    if (i_parade_clr) begin
      parade_d = 1'b0;
    end else if (i_parade_set) begin
      parade_d = 1'b1;
    end else begin
      parade_d = parade_q;
    end

    unique case (state_q)
      StGreen: begin
        if (leave) begin
          state_d    = StYellow;
          cnt_d      = '0;
          next_way_d = parade_q ? ParadeWay : rr_way;
        end
      end
      StYellow: begin
        if (cnt_q == YellowM1) begin
          state_d = StAllred;
          cnt_d   = '0;
        end
      end
      StAllred: begin
        if (cnt_q == AllredM1) begin
          state_d = StGreen;
          way_d   = next_way_q;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StGreen;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_lights = {N_WAYS{2'b10}};
    for (int unsigned k = 0; k < N_WAYS; k++) begin
      if (WAY_W'(k) == way_q) begin
        if (state_q == StGreen) begin
          o_lights[2*k +: 2] = 2'b00;
        end else if (state_q == StYellow) begin
          o_lights[2*k +: 2] = 2'b01;
        end
      end
    end
    o_active_way = way_q;
    o_parade     = parade_q;
  end

endmodule

// File: tb/tb_multi_way_traffic_ctrl.sv
// Bench for multi_way_traffic_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level model of the intersection rules.
module tb_multi_way_traffic_ctrl;

  localparam int N      = 4;
  localparam int MIN_G  = 4;
  localparam int MAX_G  = 10;
  localparam int YEL    = 3;
  localparam int ALLRED = 1;
  localparam int PW     = 1;
  localparam int SATMAX = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] sensor = '0;
  logic       pset = 1'b0;
  logic       pclr = 1'b0;
  logic [7:0] lights;
  logic [1:0] active_way;
  logic       parade;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: phase 0 = green, 1 = yellow, 2 = all red.
  int m_phase = 0;
  int m_way = 0;
  int m_cnt = 0;
  int m_next = 0;
  bit m_parade = 0;

  multi_way_traffic_ctrl dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sensor     (sensor),
    .i_parade_set (pset),
    .i_parade_clr (pclr),
    .o_lights     (lights),
    .o_active_way (active_way),
    .o_parade     (parade)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit others;
    bit go;
    bit new_par;
    if (rst) begin
      m_phase = 0; m_way = 0; m_cnt = 0; m_next = 0; m_parade = 0;
      return;
    end
    new_par = pclr ? 1'b0 : (pset ? 1'b1 : m_parade);
    case (m_phase)
      0: begin
        others = 0;
        for (int w = 0; w < N; w++) if (w != m_way && sensor[w]) others = 1;
        if (m_parade) go = (m_way != PW) && (m_cnt >= MIN_G - 1);
        else go = others && (m_cnt >= MIN_G - 1) && (!sensor[m_way] || m_cnt >= MAX_G - 1);
        if (go) begin
          if (m_parade) m_next = PW;
          else begin
            m_next = m_way;
            for (int d = N - 1; d >= 1; d--) if (sensor[(m_way + d) % N]) m_next = (m_way + d) % N;
          end
          m_phase = 1; m_cnt = 0;
        end else if (m_cnt < SATMAX) m_cnt++;
      end
      1: begin
        if (m_cnt == YEL - 1) begin m_phase = 2; m_cnt = 0; end
        else m_cnt++;
      end
      default: begin
        if (m_cnt == ALLRED - 1) begin m_phase = 0; m_way = m_next; m_cnt = 0; end
        else m_cnt++;
      end
    endcase
    m_parade = new_par;
  endtask

  function automatic logic [10:0] model_out();
    logic [7:0] l;
    for (int k = 0; k < N; k++) begin
      if (k == m_way && m_phase == 0) l[2*k +: 2] = 2'b00;
      else if (k == m_way && m_phase == 1) l[2*k +: 2] = 2'b01;
      else l[2*k +: 2] = 2'b10;
    end
    return {l, 2'(m_way), m_parade};
  endfunction

  function automatic int green_of(input logic [7:0] l);
    for (int k = 0; k < N; k++) if (l[2*k +: 2] == 2'b00) return k;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pset = 1'b0; pclr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sensor = 4'b0110;
    do_reset();
    tests_run++;
    if ({lights, active_way, parade} !== {8'b10101000, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset: got lights=%b way=%0d parade=%b, want 10101000/0/0",
               lights, active_way, parade);
    end
  endtask

  task automatic test_idle_rest();
    sensor = 4'b0000;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== {8'b10101000, 2'd0, 1'b0}) begin
        tests_failed++;
        $display("FAIL idle_rest cyc%0d: got %b/%0d/%b, want 10101000/0/0",
                 c, lights, active_way, parade);
      end
    end
  endtask

  task automatic test_single_request();
    sensor = 4'b0100;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== model_out()) begin
        tests_failed++;
        $display("FAIL single_req cyc%0d: got %b, want %b", c, {lights, active_way, parade},
                 model_out());
      end
      if (c == 4 || c == 7 || c == 8) begin
        tests_run++;
        if (lights !== (c == 4 ? 8'b10101001 : (c == 7 ? 8'b10101010 : 8'b10001010))) begin
          tests_failed++;
          $display("FAIL single_req_phase cyc%0d: got lights=%b", c, lights);
        end
      end
    end
    tests_run++;
    if (active_way !== 2'd2 || lights !== 8'b10001010) begin
      tests_failed++;
      $display("FAIL single_req_rest: got way=%0d lights=%b, want 2/10001010", active_way, lights);
    end
  endtask

  task automatic test_all_request();
    int order[$];
    int want_order[4] = '{1, 2, 3, 0};
    int prev_g, g, start;
    sensor = 4'b1111;
    do_reset();
    prev_g = green_of(lights);
    start = 0;
    for (int t = 1; t <= 60; t++) begin
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== model_out()) begin
        tests_failed++;
        $display("FAIL all_req cyc%0d: got %b, want %b", t, {lights, active_way, parade},
                 model_out());
      end
      g = green_of(lights);
      if (g != prev_g) begin
        if (prev_g >= 0) begin
          tests_run++;
          if (t - start != MAX_G) begin
            tests_failed++;
            $display("FAIL all_req_len way%0d: got %0d cycles, want %0d", prev_g, t - start, MAX_G);
          end
        end
        if (g >= 0) begin order.push_back(g); start = t; end
      end
      prev_g = g;
    end
    tests_run++;
    if (order.size() != 4) begin
      tests_failed++;
      $display("FAIL all_req_order: got %0d green entries, want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (order[i] != want_order[i]) begin
          tests_failed++;
          $display("FAIL all_req_order[%0d]: got way%0d, want way%0d", i, order[i], want_order[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int order[$];
    int prev_g, g;
    sensor = 4'b1000;
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    tests_run++;
    if (active_way !== 2'd3 || lights !== 8'b00101010) begin
      tests_failed++;
      $display("FAIL wrap_setup: got way=%0d lights=%b, want 3/00101010", active_way, lights);
    end
    sensor = 4'b0101;
    prev_g = 3;
    for (int t = 1; t <= 30; t++) begin
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== model_out()) begin
        tests_failed++;
        $display("FAIL wrap cyc%0d: got %b, want %b", t, {lights, active_way, parade}, model_out());
      end
      g = green_of(lights);
      if (g != prev_g && g >= 0) order.push_back(g);
      prev_g = g;
    end
    tests_run++;
    if (order.size() != 2 || order[0] != 0 || order[1] != 2) begin
      tests_failed++;
      $display("FAIL wrap_order: got %p, want '{0,2}", order);
    end
  endtask

  task automatic test_parade();
    sensor = 4'b0100;
    do_reset();
    for (int c = 0; c < 9; c++) tick();
    sensor = 4'b1111;
    pset = 1'b1;
    tick();
    pset = 1'b0;
    for (int t = 1; t <= 70; t++) begin
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== model_out()) begin
        tests_failed++;
        $display("FAIL parade_hold cyc%0d: got %b, want %b", t, {lights, active_way, parade},
                 model_out());
      end
    end
    tests_run++;
    if ({lights, active_way, parade} !== {8'b10100010, 2'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL parade_held: got %b/%0d/%b, want 10100010/1/1", lights, active_way, parade);
    end
    pclr = 1'b1;
    tick();
    pclr = 1'b0;
    tests_run++;
    if ({lights, parade} !== {8'b10100010, 1'b0}) begin
      tests_failed++;
      $display("FAIL parade_clr: got lights=%b parade=%b, want 10100010/0", lights, parade);
    end
    tick();
    tests_run++;
    if (lights !== 8'b10100110) begin
      tests_failed++;
      $display("FAIL parade_leave: got lights=%b, want 10100110", lights);
    end
    for (int t = 0; t < 4; t++) tick();
    tests_run++;
    if (lights !== 8'b10001010 || active_way !== 2'd2) begin
      tests_failed++;
      $display("FAIL parade_next: got lights=%b way=%0d, want 10001010/2", lights, active_way);
    end
    pset = 1'b1; pclr = 1'b1;
    tick();
    pset = 1'b0; pclr = 1'b0;
    tests_run++;
    if (parade !== 1'b0) begin
      tests_failed++;
      $display("FAIL parade_set_clr: got parade=%b, want 0", parade);
    end
  endtask

  task automatic test_reset_mid_yellow();
    int budget;
    sensor = 4'b1000;
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    pset = 1'b1;
    tick();
    pset = 1'b0;
    budget = 0;
    while (m_phase != 1 && budget < 20) begin tick(); budget++; end
    tests_run++;
    if (lights !== 8'b01101010 || parade !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_yel_setup: got lights=%b parade=%b, want 01101010/1", lights, parade);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({lights, active_way, parade} !== {8'b10101000, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_mid_yellow: got %b/%0d/%b, want 10101000/0/0", lights, active_way, parade);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      sensor = 4'($urandom_range(0, 15));
      pset = ($urandom_range(0, 99) < 3);
      pclr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) == 0);
      tick();
      tests_run++;
      if ({lights, active_way, parade} !== model_out()) begin
        tests_failed++;
        $display("FAIL random cyc%0d: got %b, want %b", c, {lights, active_way, parade},
                 model_out());
      end
    end
    rst = 1'b0; pset = 1'b0; pclr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_rest();
    test_single_request();
    test_all_request();
    test_wrap();
    test_parade();
    test_reset_mid_yellow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
